hilo_muldiv_seq: RTL and testbench
==================================

# hilo_muldiv_seq

Multi-cycle multiply/divide sequencer that owns the single HI/LO write port. It accepts MULT/MULTU/DIV/DIVU operations from the EXE stage and runs them iteratively over 32 cycles. While running it stalls the pipeline through `o_busy`, then writes the 64-bit result to HI/LO in one cycle. When idle it also carries MTHI/MTLO writes, so HI/LO have exactly one writer.

## Interface
Parameters:
- `ITER`, 32, number of iteration cycles; fixed at 32 for 32-bit operands.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  operation request; sampled only in IDLE.
- `i_func`  in  4  4'd1 MULT, 4'd2 MULTU, 4'd3 DIV, 4'd4 DIVU; any other value is a no-op.
- `i_a`  in  32  rs operand (multiplicand or dividend).
- `i_b`  in  32  rt operand (multiplier or divisor).
- `i_mthi`  in  1  MTHI request; sampled only in IDLE.
- `i_mtlo`  in  1  MTLO request; sampled only in IDLE.
- `i_mt_data`  in  32  data for MTHI/MTLO.
- `i_flush`  in  1  exception or branch flush; cancels any operation in flight.
- `o_busy`  out  1  stall request to the pipeline; high while state ≠ IDLE.
- `o_hi_ena`  out  1  HI write enable, one-cycle pulse.
- `o_hi_idata`  out  32  HI write data.
- `o_lo_ena`  out  1  LO write enable, one-cycle pulse.
- `o_lo_idata`  out  32  LO write data.
- `o_done`  out  1  one-cycle pulse in the WRITE state.

## Operation
State machine: IDLE → CALC → FIXUP → WRITE → IDLE.

- **IDLE**
  - `i_start` with a valid `i_func`: latch `|a|` and `|b|` (absolute values for signed ops, raw values for unsigned), latch the sign flags, clear the 6-bit counter, go to CALC.
  - `i_start` with an invalid `i_func`: ignored; stay in IDLE.
- **CALC**: one iteration per cycle; counter increments; after iteration 31 go to FIXUP.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring division, 64-bit remainder/quotient register; one subtract-compare per cycle.
- **FIXUP**
  - Signed multiply: negate the product if `a[31]^b[31]`.
  - Signed divide: negate the quotient if `a[31]^b[31]`; negate the remainder if `a[31]`.
  - All arithmetic is two's complement, results truncated to 32/64 bits.
- **WRITE**: drive result, then return to IDLE.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: HI = remainder, LO = quotient.
  - `o_hi_ena`, `o_lo_ena` and `o_done` are high for this cycle only.

Edge cases:
- Divide by zero (`i_b == 0`): HI = `i_a` (original value), LO = 32'hFFFF_FFFF, for both DIV and DIVU. Same 34-cycle latency.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.

MTHI/MTLO pass-through (IDLE only):
- `i_mthi` → next cycle `o_hi_ena` = 1, `o_hi_idata` = `i_mt_data`.
- `i_mtlo` → same for LO.
- Both may be asserted together; both enables pulse.

Arbitration and flush:
- `i_start` together with `i_mthi`/`i_mtlo` in the same cycle: start wins and the MT request is dropped.
- In non-IDLE states, `i_start`, `i_mthi` and `i_mtlo` are ignored; the pipeline is frozen by `o_busy`.
- `i_flush` has highest priority in every state: next state is IDLE, no HI/LO write, no `o_done`. A start or MT request in the flush cycle is discarded.
- `o_hi_idata` and `o_lo_idata` are don't-care when their enable is low.

## Timing
- Reset (asynchronous): state = IDLE, counter = 0, internal registers = 0; every output = 0.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- Start accepted at edge N:
  - `o_busy` = 1 from after edge N through the WRITE cycle.
  - CALC occupies edges N+1..N+32; FIXUP is at edge N+33.
  - WRITE cycle follows edge N+33; `o_busy` drops after edge N+34.
  - Total latency 34 cycles. A new start is accepted at edge N+35 at the earliest.
- MT request at edge M: write pulse in the cycle after M; `o_busy` stays 0.
- `i_flush` at edge F: `o_busy` = 0 after F.
- `rst` mid-operation: immediate return to IDLE with no write.

## Test plan
- **MULTU**: a = 0xFFFF_FFFF, b = 0xFFFF_FFFF → after 34 cycles, single pulse with HI = 0xFFFF_FFFE, LO = 0x0000_0001; `o_busy` high exactly 34 cycles.
- **MULT**: a = −3 (0xFFFF_FFFD), b = 7 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB.
- **DIV / DIVU**:
  - DIV −7 / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
  - DIVU 100 / 7 → LO = 14, HI = 2.
  - DIV 0x8000_0000 / −1 → LO = 0x8000_0000, HI = 0.
  - DIVU 5 / 0 → HI = 5, LO = 0xFFFF_FFFF.
- **Flush**: start MULT, then `i_flush` at cycle 10 → `o_busy` low next cycle, no HI/LO enable ever; the next MULTU 2×3 yields LO = 6, HI = 0.
- **MT pass-through and arbitration**:
  - In IDLE, `i_mthi` with data 0x1234_5678 → `o_hi_ena` pulse next cycle with that data.
  - `i_start` + `i_mtlo` in the same cycle → only the muldiv result is written.
  - MT requests during busy → no writes.
- **Reset**: assert `rst` at cycle 20 of a DIVU → all outputs 0 immediately, no write after release, and a new op completes normally.

Source files
------------

// File: rtl/hilo_muldiv_seq_if.sv
// Bundle between the EXE stage and the HI/LO multiply/divide sequencer.
// Requests (i_start, i_mthi, i_mtlo) are taken on a rising edge only while o_busy is low and
// i_flush is low; o_busy acts as not-ready. o_hi_ena/o_lo_ena/o_done are one-cycle valid strobes
// with no back-pressure, and their data is meaningful only while the matching enable is high.
interface hilo_muldiv_seq_if;
  logic        i_start;
  logic [3:0]  i_func;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_mthi;
  logic        i_mtlo;
  logic [31:0] i_mt_data;
  logic        i_flush;
  logic        o_busy;
  logic        o_hi_ena;
  logic [31:0] o_hi_idata;
  logic        o_lo_ena;
  logic [31:0] o_lo_idata;
  logic        o_done;
  logic [1:0]  o_state;

  modport master (
    output i_start, i_func, i_a, i_b, i_mthi, i_mtlo, i_mt_data, i_flush,
    input  o_busy, o_hi_ena, o_hi_idata, o_lo_ena, o_lo_idata, o_done, o_state
  );

  modport slave (
    input  i_start, i_func, i_a, i_b, i_mthi, i_mtlo, i_mt_data, i_flush,
    output o_busy, o_hi_ena, o_hi_idata, o_lo_ena, o_lo_idata, o_done, o_state
  );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer and sole writer of HI/LO (also carries MTHI/MTLO).
// Operands are reduced to magnitudes, iterated 32 cycles, sign-corrected in FIXUP, written in WRITE.
module hilo_muldiv_seq #(
  parameter int ITER = 32
) (
  input logic               clk,
  input logic               rst,
  hilo_muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_WRITE} state_t;

  localparam logic [5:0] LAST_ITER = 6'(ITER - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opnd_q;
  logic        is_div_q, neg_q_q, neg_r_q, div_zero_q;
  logic        hi_ena_q, lo_ena_q, done_q;
  logic [31:0] hi_data_q, lo_data_q;

  logic        func_valid, func_signed, func_div, start_ok;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, rem_sh;
  logic [33:0] div_diff;
  logic [63:0] step_acc, prod;
  logic [31:0] res_hi, res_lo;

  assign func_valid  = (bus.i_func >= 4'd1) && (bus.i_func <= 4'd4);
  assign func_signed = (bus.i_func == 4'd1) || (bus.i_func == 4'd3);
  assign func_div    = (bus.i_func == 4'd3) || (bus.i_func == 4'd4);
  assign start_ok    = (state_q == S_IDLE) && bus.i_start && func_valid && !bus.i_flush;
  assign abs_a       = (func_signed && bus.i_a[31]) ? -bus.i_a : bus.i_a;
  assign abs_b       = (func_signed && bus.i_b[31]) ? -bus.i_b : bus.i_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_ok) state_d = S_CALC;
        S_CALC:  if (cnt_q == LAST_ITER) state_d = S_FIXUP;
        S_FIXUP: state_d = S_WRITE;
        S_WRITE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Multiply: shift-add with the multiplier in the low half. Divide: restoring, with the
  // dividend shifting out of the low half; the shifted remainder needs 33 bits before the compare.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    rem_sh   = {acc_q[63:32], acc_q[31]};
    div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
    if (!is_div_q)        step_acc = {mul_sum, acc_q[31:1]};
    else if (div_diff[33]) step_acc = {rem_sh[31:0], acc_q[30:0], 1'b0};
    else                  step_acc = {div_diff[31:0], acc_q[30:0], 1'b1};
  end

  // Divide by zero leaves remainder = |a| and quotient all ones; negating the remainder by a's
  // sign restores the original a, so only LO needs forcing.
  always_comb begin
    prod   = neg_q_q ? -acc_q : acc_q;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div_q) begin
      res_hi = neg_r_q ? -acc_q[63:32] : acc_q[63:32];
      res_lo = div_zero_q ? 32'hFFFF_FFFF : (neg_q_q ? -acc_q[31:0] : acc_q[31:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_ena_q   <= 1'b0;
      lo_ena_q   <= 1'b0;
      done_q     <= 1'b0;
      hi_data_q  <= '0;
      lo_data_q  <= '0;
    end else begin
      hi_ena_q <= 1'b0;
      lo_ena_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            cnt_q      <= '0;
            is_div_q   <= func_div;
            neg_q_q    <= func_signed && (bus.i_a[31] ^ bus.i_b[31]);
            neg_r_q    <= func_signed && bus.i_a[31];
            div_zero_q <= func_div && (bus.i_b == 32'd0);
            acc_q      <= func_div ? {32'd0, abs_a} : {32'd0, abs_b};
            opnd_q     <= func_div ? abs_b : abs_a;
          end else if (!bus.i_flush && !(bus.i_start && func_valid)) begin
            if (bus.i_mthi) begin
              hi_ena_q  <= 1'b1;
              hi_data_q <= bus.i_mt_data;
            end
            if (bus.i_mtlo) begin
              lo_ena_q  <= 1'b1;
              lo_data_q <= bus.i_mt_data;
            end
          end
        end
        S_CALC: begin
          acc_q <= step_acc;
          cnt_q <= cnt_q + 6'd1;
        end
        S_FIXUP: begin
          if (!bus.i_flush) begin
            hi_ena_q  <= 1'b1;
            lo_ena_q  <= 1'b1;
            done_q    <= 1'b1;
            hi_data_q <= res_hi;
            lo_data_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_hi_ena   = hi_ena_q;
  assign bus.o_lo_ena   = lo_ena_q;
  assign bus.o_hi_idata = hi_data_q;
  assign bus.o_lo_idata = lo_data_q;
  assign bus.o_done     = done_q;
  assign bus.o_state    = state_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Bench for hilo_muldiv_seq: directed and random operations against an arithmetic model,
// plus MT pass-through, arbitration, flush and mid-operation reset.
module tb_hilo_muldiv_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_seq_if bus ();

  hilo_muldiv_seq #(.ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int done_total = 0;
  logic [65:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.o_hi_ena || bus.o_lo_ena) wr_total++;
    if (bus.o_done) done_total++;
  end

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition of each op.
  function automatic logic [63:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      4'd1: model = 64'(sa * sb);
      4'd2: model = ua * ub;
      4'd3: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          model = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else model = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  task automatic idle_inputs();
    bus.i_start   = 1'b0;
    bus.i_func    = 4'd0;
    bus.i_a       = '0;
    bus.i_b       = '0;
    bus.i_mthi    = 1'b0;
    bus.i_mtlo    = 1'b0;
    bus.i_mt_data = '0;
    bus.i_flush   = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input bit mt_same);
    int busy_cnt, wr_cnt, wr_at, done_cnt;
    logic [65:0] got, exp;
    string tag;
    tag = $sformatf("op f=%0d a=%h b=%h", f, a, b);
    exp_q.push_back({2'b11, model(f, a, b)});
    @(negedge clk);
    check({tag, " idle_before"}, 66'(bus.o_busy), 66'd0);
    bus.i_start = 1'b1;
    bus.i_func  = f;
    bus.i_a     = a;
    bus.i_b     = b;
    if (mt_same) begin
      bus.i_mthi    = 1'b1;
      bus.i_mtlo    = 1'b1;
      bus.i_mt_data = $urandom;
    end
    @(posedge clk);
    #1 idle_inputs();
    busy_cnt = 0; wr_cnt = 0; wr_at = 0; done_cnt = 0; got = '0;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      if (bus.o_busy) busy_cnt++;
      if (bus.o_hi_ena || bus.o_lo_ena) begin
        wr_cnt++;
        wr_at = k;
        got = {bus.o_hi_ena, bus.o_lo_ena, bus.o_hi_idata, bus.o_lo_idata};
      end
      if (bus.o_done) done_cnt++;
      if (noise && k < 33) begin
        bus.i_start   = 1'($urandom_range(0, 1));
        bus.i_func    = 4'($urandom_range(1, 4));
        bus.i_a       = $urandom;
        bus.i_b       = $urandom;
        bus.i_mthi    = 1'($urandom_range(0, 1));
        bus.i_mtlo    = 1'($urandom_range(0, 1));
        bus.i_mt_data = $urandom;
      end else begin
        idle_inputs();
      end
    end
    idle_inputs();
    exp = exp_q.pop_front();
    check({tag, " busy_cycles"}, 66'(busy_cnt), 66'd34);
    check({tag, " write_count"}, 66'(wr_cnt), 66'd1);
    check({tag, " write_cycle"}, 66'(wr_at), 66'd34);
    check({tag, " done_count"}, 66'(done_cnt), 66'd1);
    check({tag, " result"}, got, exp);
  endtask

  task automatic mt_op(input bit hi, input bit lo, input logic [31:0] d);
    logic [65:0] obs;
    @(negedge clk);
    bus.i_mthi = hi;
    bus.i_mtlo = lo;
    bus.i_mt_data = d;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    obs = {bus.o_hi_ena, bus.o_lo_ena, bus.o_hi_ena ? bus.o_hi_idata : 32'd0,
           bus.o_lo_ena ? bus.o_lo_idata : 32'd0};
    check($sformatf("mt hi=%0d lo=%0d", hi, lo), obs, {hi, lo, hi ? d : 32'd0, lo ? d : 32'd0});
    check("mt busy", 66'(bus.o_busy), 66'd0);
    @(negedge clk);
    check("mt single_pulse", 66'({bus.o_hi_ena, bus.o_lo_ena}), 66'd0);
  endtask

  initial begin
    int w0, d0;
    logic [3:0] f;
    logic [31:0] a, b;
    idle_inputs();
    rst = 1'b1;
    #1;
    check("reset ctrl", 66'({bus.o_busy, bus.o_hi_ena, bus.o_lo_ena, bus.o_done, bus.o_state}), 66'd0);
    check("reset data", 66'({bus.o_hi_idata, bus.o_lo_idata}), 66'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(4'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(4'd4, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op(4'd3, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);

    mt_op(1'b1, 1'b0, 32'h1234_5678);
    mt_op(1'b0, 1'b1, 32'hCAFE_F00D);
    mt_op(1'b1, 1'b1, 32'hA5A5_0F0F);

    run_op(4'd1, 32'h0001_2345, 32'hFFFE_0001, 1'b0, 1'b1);
    run_op(4'd4, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 1'b0);

    // Invalid function codes are ignored.
    w0 = wr_total;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_func  = 4'd9;
    @(posedge clk);
    #1 idle_inputs();
    repeat (3) @(negedge clk);
    check("invalid_func busy", 66'(bus.o_busy), 66'd0);
    check("invalid_func no_write", 66'(wr_total), 66'(w0));

    // Flush part way through a MULT.
    w0 = wr_total;
    d0 = done_total;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_func  = 4'd1;
    bus.i_a     = $urandom;
    bus.i_b     = $urandom;
    @(posedge clk);
    #1 idle_inputs();
    repeat (9) @(negedge clk);
    bus.i_flush = 1'b1;
    bus.i_mthi  = 1'b1;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("flush busy_low", 66'(bus.o_busy), 66'd0);
    repeat (40) @(negedge clk);
    check("flush no_write", 66'(wr_total), 66'(w0));
    check("flush no_done", 66'(done_total), 66'(d0));
    run_op(4'd2, 32'd2, 32'd3, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a DIVU.
    w0 = wr_total;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_func  = 4'd4;
    bus.i_a     = 32'hFFFF_0000;
    bus.i_b     = 32'd3;
    @(posedge clk);
    #1 idle_inputs();
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midop_reset ctrl", 66'({bus.o_busy, bus.o_hi_ena, bus.o_lo_ena, bus.o_done, bus.o_state}), 66'd0);
    check("midop_reset data", 66'({bus.o_hi_idata, bus.o_lo_idata}), 66'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midop_reset no_write", 66'(wr_total), 66'(w0));
    run_op(4'd4, 32'hFFFF_0000, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      f = 4'($urandom_range(1, 4));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(f, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
